imem_load_ctrl: RTL and testbench

//  Boot-time controller for the instruction memory. It takes a byte stream
//  (from a UART/host bridge) and assembles it into 32-bit words. It writes those

---
 rtl/imem_load_pkg.sv | 24 ++
 rtl/imem_word_pack.sv | 56 +++++
 rtl/imem_load_ctrl.sv | 142 ++++++++++++++
 tb/tb_imem_load_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_pkg.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_pkg
// Brief   : Shared types and constants for the instruction-memory boot loader.
//           Optional feature macro: IMEM_LOAD_CSUM_EN (adds the CSUM state).
// Revision: 1.0  initial release
// ============================================================================
package imem_load_pkg;

  localparam int LEN_W          = 16;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_pack.sv
`default_nettype none
// ============================================================================
// Module  : imem_word_pack
// Brief   : Packs little-endian bytes into words. Issues a one-cycle
//           word_valid the cycle after the last byte of a word is taken.
// Revision: 1.0  initial release
// ============================================================================
module imem_word_pack
  import imem_load_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_last,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_data
);

  localparam logic [1:0] c_LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0]        r_cnt;
  // Bytes shift in from the top so the first byte ends up in the low lane.
  logic [WORD_W-9:0] r_acc;

  assign in_last = in_valid && (r_cnt == c_LAST_IDX);

  // Byte counter, shift accumulator and registered word output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      word_valid <= 1'b0;
      word_data  <= '0;
    end else if (clr) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        r_cnt <= r_cnt + 2'd1;
        r_acc <= {in_data, r_acc[WORD_W-9:8]};
        if (in_last) begin
          word_data  <= {in_data, r_acc};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_ctrl
// Brief   : Boot-time instruction memory loader. Parses a length-prefixed byte
//           stream, writes words sequentially and stalls fetch until done.
//           Optional feature macro: IMEM_LOAD_CSUM_EN (trailing XOR checksum).
// Revision: 1.0  initial release
// ============================================================================
module imem_load_ctrl
  import imem_load_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 8192,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              core_stall,
  output logic              load_done,
  output logic              load_err
);

  state_t            r_state;
  logic [7:0]        r_len_lo;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_widx;

  logic              w_accept;
  logic              w_start_ok;
  logic              w_pack_in;
  logic              w_pack_last;
  logic              w_final_word;
  logic [LEN_W-1:0]  w_len_full;

  // Status outputs are pure decodes of the state register.
  assign byte_ready = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                      (r_state == ST_DATA) || (r_state == ST_CSUM);
  assign core_stall = (r_state != ST_DONE);
  assign load_done  = (r_state == ST_DONE);
  assign load_err   = (r_state == ST_ERR);

  assign w_accept     = byte_valid && byte_ready;
  assign w_start_ok   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_pack_in    = w_accept && (r_state == ST_DATA);
  assign w_len_full   = {byte_data, r_len_lo};
  // r_widx already points at the word being assembled here.
  assign w_final_word = (LEN_W'(r_widx) == (r_len - LEN_W'(1)));
  assign mem_waddr    = r_widx;

  imem_word_pack #(
    .WORD_W (WORD_W)
  ) u_pack (
    .CLK        (CLK),
    .RST        (RST),
    .clr        (w_start_ok),
    .in_valid   (w_pack_in),
    .in_data    (byte_data),
    .in_last    (w_pack_last),
    .word_valid (mem_we),
    .word_data  (mem_wdata)
  );

`ifdef IMEM_LOAD_CSUM_EN
  logic [7:0] r_csum;

  // Running XOR over payload bytes only.
  always_ff @(posedge CLK) begin
    if (RST || w_start_ok) begin
      r_csum <= '0;
    end else if (w_pack_in) begin
      r_csum <= r_csum ^ byte_data;
    end
  end
`endif

  // Load sequencer: length header, payload, optional checksum, status.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_len_lo <= '0;
      r_len    <= '0;
      r_widx   <= '0;
    end else begin
      // Advance past a non-final word once its write has been issued.
      if (mem_we && (r_state == ST_DATA)) begin
        r_widx <= r_widx + 1'b1;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) r_state <= ST_LEN0;
        end
        ST_LEN0: begin
          if (w_accept) begin
            r_len_lo <= byte_data;
            r_state  <= ST_LEN1;
          end
        end
        ST_LEN1: begin
          if (w_accept) begin
            r_len  <= w_len_full;
            r_widx <= '0;
            if (w_len_full == '0)                  r_state <= ST_DONE;
            else if (w_len_full > LEN_W'(DEPTH))   r_state <= ST_ERR;
            else                                   r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          // Leave on the same edge that launches the final write.
          if (w_pack_last && w_final_word) begin
`ifdef IMEM_LOAD_CSUM_EN
            r_state <= ST_CSUM;
`else
            r_state <= ST_DONE;
`endif
          end
        end
`ifdef IMEM_LOAD_CSUM_EN
        ST_CSUM: begin
          if (w_accept) begin
            r_state <= (byte_data == r_csum) ? ST_DONE : ST_ERR;
          end
        end
`endif
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_imem_load_ctrl
// Brief   : Self-checking bench for imem_load_ctrl with a frame-level model.
//           Honours IMEM_LOAD_CSUM_EN when defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_imem_load_ctrl;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;
  localparam int WORD_W = 32;
`ifdef IMEM_LOAD_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_LEN0 = 1, P_LEN1 = 2, P_DATA = 3,
                 P_CSUM = 4, P_DONE = 5, P_ERR = 6;

  typedef logic [7:0] bq_t[$];

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              start = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [WORD_W-1:0] mem_wdata;
  logic              core_stall;
  logic              load_done;
  logic              load_err;

  imem_load_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .core_stall (core_stall),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Written image as seen on the memory port.
  logic [31:0] tb_mem [0:DEPTH-1];
  int          wr_count = 0;
  logic        last_we_stall = 1'b1;

  // Frame-level model: phase, length, payload byte count, running word/csum.
  int          m_phase = P_IDLE;
  int          m_len   = 0;
  int          m_lo    = 0;
  int          m_pb    = 0;
  logic [31:0] m_word  = 32'h0;
  logic [7:0]  m_csum  = 8'h00;
  logic        m_we    = 1'b0;
  int          m_waddr = 0;
  logic [31:0] m_wdata = 32'h0;
  bit          cmp_en  = 1'b0;

  function automatic bit m_ready(input int p);
    return (p == P_LEN0) || (p == P_LEN1) || (p == P_DATA) || (p == P_CSUM);
  endfunction

  task automatic model_step();
    bit acc;
    acc  = byte_valid && m_ready(m_phase);
    m_we = 1'b0;
    if (RST) begin
      m_phase = P_IDLE;
      m_pb    = 0;
      m_word  = 32'h0;
      m_csum  = 8'h00;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: if (start) begin
          m_phase = P_LEN0; m_csum = 8'h00; m_pb = 0; m_word = 32'h0;
        end
        P_LEN0: if (acc) begin m_lo = int'(byte_data); m_phase = P_LEN1; end
        P_LEN1: if (acc) begin
          m_len = int'(byte_data) * 256 + m_lo;
          m_pb = 0; m_word = 32'h0;
          if (m_len == 0)          m_phase = P_DONE;
          else if (m_len > DEPTH)  m_phase = P_ERR;
          else                     m_phase = P_DATA;
        end
        P_DATA: if (acc) begin
          m_word = m_word | (32'(byte_data) << (8 * (m_pb % 4)));
          m_csum = m_csum ^ byte_data;
          m_pb++;
          if (m_pb % 4 == 0) begin
            m_we = 1'b1; m_waddr = m_pb / 4 - 1; m_wdata = m_word; m_word = 32'h0;
            if (m_pb == 4 * m_len) m_phase = CSUM_EN ? P_CSUM : P_DONE;
          end
        end
        P_CSUM: if (acc) m_phase = (byte_data == m_csum) ? P_DONE : P_ERR;
        default: ;
      endcase
    end
  endtask

  // Compare DUT against the model, capture writes, then advance the model.
  always @(negedge CLK) begin
    if (cmp_en) begin
      chk("ctrl{rdy,stall,done,err,we}",
          {byte_ready, core_stall, load_done, load_err, mem_we},
          {m_ready(m_phase), m_phase != P_DONE, m_phase == P_DONE, m_phase == P_ERR, m_we});
      if (m_we) begin
        chk("waddr", mem_waddr, m_waddr);
        chk("wdata", mem_wdata, m_wdata);
      end
    end
    if (mem_we) begin
      tb_mem[mem_waddr] = mem_wdata;
      wr_count++;
      last_we_stall = core_stall;
    end
    model_step();
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer bytes with random gaps and random (ignored) start pulses.
  task automatic send_bytes(input bq_t q);
    int i = 0;
    int guard = 0;
    while (i < q.size() && guard < 4000) begin
      byte_valid = ($urandom_range(0, 3) != 0);
      byte_data  = byte_valid ? q[i] : 8'($urandom);
      start      = ($urandom_range(0, 7) == 0);
      @(negedge CLK);
      if (byte_valid && byte_ready) i++;
      tick();
      guard++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    if (guard >= 4000) chk("send_timeout", 64'(i), 64'(q.size()));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         fq;
    logic [31:0] ew [0:7];
    int          w0;
    int          n;
    logic [7:0]  cs;
    logic [7:0]  b;

    tick();
    cmp_en = 1'b1;
    tick();
    tick();
    RST = 1'b0;

    // Bytes offered in IDLE must be ignored.
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    repeat (3) tick();
    chk("idle_ready", byte_ready, 0);
    chk("idle_stall", core_stall, 1);
    chk("idle_we",    mem_we,     0);
    chk("rst_waddr",  mem_waddr,  0);
    chk("rst_wdata",  mem_wdata,  0);
    chk("rst_done",   load_done,  0);
    byte_valid = 1'b0;

    // Two-word image.
    pulse_start();
    fq = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM_EN) fq.push_back(8'h90);
    send_bytes(fq);
    tick(); tick();
    chk("img2_w0", tb_mem[0], 32'h0000_0013);
    chk("img2_w1", tb_mem[1], 32'h0010_0093);
    chk("img2_done", load_done, 1);
    chk("img2_stall", core_stall, 0);
    chk("stall_at_last_we", last_we_stall, CSUM_EN);

    // Empty image.
    w0 = wr_count;
    pulse_start();
    fq = {8'h00, 8'h00};
    send_bytes(fq);
    tick();
    chk("empty_done", load_done, 1);
    chk("empty_nowrite", wr_count, w0);

    // Random images.
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 6);
      fq = {8'(n), 8'h00};
      cs = 8'h00;
      for (int k = 0; k < n; k++) begin
        ew[k] = 32'h0;
        for (int j = 0; j < 4; j++) begin
          b = 8'($urandom);
          fq.push_back(b);
          cs = cs ^ b;
          ew[k] = ew[k] | (32'(b) << (8 * j));
        end
      end
      if (CSUM_EN) fq.push_back(cs);
      pulse_start();
      send_bytes(fq);
      tick(); tick();
      chk("rand_done", load_done, 1);
      for (int k = 0; k < n; k++) chk("rand_img", tb_mem[k], ew[k]);
    end

    // N = DEPTH is legal: enters payload phase.
    pulse_start();
    fq = {8'h00, 8'h20};
    send_bytes(fq);
    tick();
    chk("depth_ok_err", load_err, 0);
    chk("depth_ok_rdy", byte_ready, 1);
    RST = 1'b1; tick(); RST = 1'b0;

    // N = DEPTH+1 is rejected, and start cannot leave ERR.
    w0 = wr_count;
    pulse_start();
    fq = {8'h01, 8'h20};
    send_bytes(fq);
    tick();
    chk("ovf_err", load_err, 1);
    chk("ovf_stall", core_stall, 1);
    pulse_start();
    tick(); tick();
    chk("ovf_sticky", load_err, 1);
    chk("ovf_rdy", byte_ready, 0);
    chk("ovf_nowrite", wr_count, w0);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("ovf_cleared", load_err, 0);

    // Reset in the middle of a word must clear the byte packer.
    pulse_start();
    fq = {8'h01, 8'h00, 8'hAA, 8'hBB};
    send_bytes(fq);
    RST = 1'b1; tick(); RST = 1'b0;
    tb_mem[0] = 32'h0;
    pulse_start();
    fq = {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    if (CSUM_EN) fq.push_back(8'h00);
    send_bytes(fq);
    tick(); tick();
    chk("rstmid_w0", tb_mem[0], 32'hDDCC_BBAA);
    chk("rstmid_done", load_done, 1);

`ifdef IMEM_LOAD_CSUM_EN
    pulse_start();
    fq = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
    send_bytes(fq);
    tick();
    chk("csum_ok_done", load_done, 1);
    tb_mem[0] = 32'h0;
    pulse_start();
    fq = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    send_bytes(fq);
    tick();
    chk("csum_bad_err", load_err, 1);
    chk("csum_bad_w0", tb_mem[0], 32'h0000_0013);
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
